// File: rtl/rv_imem_responder.sv
// Instruction-memory responder for the uRV fetch stage: word-addressed RAM with
// programmable wait states, a host load port and write-first forwarding to fetch.
module rv_imem_responder #(
    parameter int unsigned DEPTH_LOG2  = 12,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] OOR_DATA    = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] im_addr_i,
    output logic [31:0] im_data_o,
    output logic        im_valid_o,
    input  logic        ld_we_i,
    input  logic [31:0] ld_addr_i,
    input  logic [31:0] ld_data_i,
    output logic        oor_o
);

    localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] fetch_word;
    logic [DEPTH_LOG2-1:0] ld_word;
    logic [DEPTH_LOG2-1:0] addr_q;
    logic                  fetch_oor;
    logic                  ld_oor;
    logic                  ld_valid;
    logic                  oor_q;
    logic                  fresh;
    logic [3:0]            cnt;
    logic                  collision;
    logic                  accept;
    logic [31:0]           fetch_rdata;
    logic [31:0]           held_rdata;
    logic                  unused_addr_bits;

    assign fetch_word = im_addr_i[DEPTH_LOG2+1:2];
    assign fetch_oor  = |im_addr_i[31:DEPTH_LOG2+2];
    assign ld_word    = ld_addr_i[DEPTH_LOG2+1:2];
    assign ld_oor     = |ld_addr_i[31:DEPTH_LOG2+2];
    assign ld_valid   = ld_we_i && !ld_oor;

    assign unused_addr_bits = ^{im_addr_i[1:0], ld_addr_i[1:0]};

    // A load hitting the held word only forces a re-read once the response is out;
    // during a wait the write lands in RAM and is picked up at response time.
    assign collision = ld_valid && (ld_word == addr_q) && (cnt == 4'd0);
    assign accept    = fresh || (fetch_word != addr_q) || (fetch_oor != oor_q) || collision;

    always_comb begin
        fetch_rdata = mem[fetch_word];
        if (fetch_oor) begin
            fetch_rdata = OOR_DATA;
        end else if (ld_valid && (ld_word == fetch_word)) begin
            fetch_rdata = ld_data_i;
        end
    end

    always_comb begin
        held_rdata = mem[addr_q];
        if (oor_q) begin
            held_rdata = OOR_DATA;
        end else if (ld_valid && (ld_word == addr_q)) begin
            held_rdata = ld_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (ld_valid) begin
            mem[ld_word] <= ld_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q     <= '0;
            oor_q      <= 1'b0;
            fresh      <= 1'b1;
            cnt        <= 4'd0;
            im_data_o  <= 32'd0;
            im_valid_o <= 1'b0;
            oor_o      <= 1'b0;
        end else if (accept) begin
            addr_q <= fetch_word;
            oor_q  <= fetch_oor;
            fresh  <= 1'b0;
            if (WAIT_STATES == 0) begin
                im_data_o  <= fetch_rdata;
                im_valid_o <= 1'b1;
                if (fetch_oor) begin
                    oor_o <= 1'b1;
                end
            end else begin
                cnt        <= WAIT_INIT;
                im_valid_o <= 1'b0;
            end
        end else if (cnt > 4'd1) begin
            cnt        <= cnt - 4'd1;
            im_valid_o <= 1'b0;
        end else if (cnt == 4'd1) begin
            cnt        <= 4'd0;
            im_data_o  <= held_rdata;
            im_valid_o <= 1'b1;
            if (oor_q) begin
                oor_o <= 1'b1;
            end
        end else begin
            // Stalled fetch: keep presenting the held word, refreshed from RAM.
            im_data_o <= held_rdata;
        end
    end

endmodule

// File: tb/tb_rv_imem_responder.sv
// Directed bench for rv_imem_responder: one instance with no wait states and one
// with three, sharing clock, reset and the host load port.
module tb_rv_imem_responder;

    logic        clk;
    logic        rst;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic [31:0] addr0;
    logic [31:0] data0;
    logic        valid0;
    logic        oor0;
    logic [31:0] addr3;
    logic [31:0] data3;
    logic        valid3;
    logic        oor3;

    int total = 0;
    int bad   = 0;

    rv_imem_responder #(.DEPTH_LOG2(12), .WAIT_STATES(0), .OOR_DATA(32'h0000_0013)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .im_addr_i(addr0), .im_data_o(data0), .im_valid_o(valid0),
        .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data), .oor_o(oor0)
    );

    rv_imem_responder #(.DEPTH_LOG2(12), .WAIT_STATES(3), .OOR_DATA(32'h0000_0013)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .im_addr_i(addr3), .im_data_o(data3), .im_valid_o(valid3),
        .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data), .oor_o(oor3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive both fetch addresses, then let one rising edge pass and settle.
    task automatic applyStimulus(input logic [31:0] a0, input logic [31:0] a3);
        addr0 = a0;
        addr3 = a3;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst     = 1'b1;
        ld_we   = 1'b0;
        ld_addr = 32'd0;
        ld_data = 32'd0;
        addr0   = 32'd0;
        addr3   = 32'd0;

        // Preload RAM through the host port while reset is held.
        ld_we = 1'b1;
        ld_addr = 32'h00; ld_data = 32'h11;        applyStimulus(32'h0, 32'h0);
        ld_addr = 32'h04; ld_data = 32'h22;        applyStimulus(32'h0, 32'h0);
        ld_addr = 32'h08; ld_data = 32'h33;        applyStimulus(32'h0, 32'h0);
        ld_addr = 32'h0C; ld_data = 32'h44;        applyStimulus(32'h0, 32'h0);
        ld_addr = 32'h10; ld_data = 32'h55;        applyStimulus(32'h0, 32'h0);
        ld_addr = 32'h20; ld_data = 32'h0808;      applyStimulus(32'h0, 32'h0);
        ld_addr = 32'h40; ld_data = 32'hA5A5_0016; applyStimulus(32'h0, 32'h0);
        ld_we = 1'b0;

        checkOutput("rst_valid0", 32'(valid0), 32'd0);
        checkOutput("rst_data0",  data0,       32'd0);
        checkOutput("rst_oor0",   32'(oor0),   32'd0);
        checkOutput("rst_valid3", 32'(valid3), 32'd0);
        checkOutput("rst_data3",  data3,       32'd0);
        checkOutput("rst_oor3",   32'(oor3),   32'd0);

        // Streaming fetch with no wait states; wait-state instance holds 0x8.
        rst = 1'b0;
        applyStimulus(32'h0, 32'h8);
        checkOutput("ws0_valid_e1", 32'(valid0), 32'd1);
        checkOutput("ws0_data_e1",  data0,       32'h11);
        checkOutput("ws3_wait_e1",  32'(valid3), 32'd0);
        applyStimulus(32'h4, 32'h8);
        checkOutput("ws0_data_e2",  data0,       32'h22);
        checkOutput("ws3_wait_e2",  32'(valid3), 32'd0);
        applyStimulus(32'h8, 32'h8);
        checkOutput("ws0_data_e3",  data0,       32'h33);
        checkOutput("ws3_wait_e3",  32'(valid3), 32'd0);
        applyStimulus(32'hC, 32'h8);
        checkOutput("ws0_data_e4",  data0,       32'h44);
        checkOutput("ws3_valid_e4", 32'(valid3), 32'd1);
        checkOutput("ws3_data_e4",  data3,       32'h33);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(32'hC, 32'h8);
            checkOutput("ws3_hold_valid", 32'(valid3), 32'd1);
            checkOutput("ws3_hold_data",  data3,       32'h33);
            checkOutput("ws0_hold_data",  data0,       32'h44);
        end

        // Redirect during a wait: 0x10 is abandoned, 0x40 answered 4 edges later.
        applyStimulus(32'hC, 32'h10);
        checkOutput("redir_old_e1", 32'(valid3), 32'd0);
        applyStimulus(32'hC, 32'h10);
        checkOutput("redir_old_e2", 32'(valid3), 32'd0);
        applyStimulus(32'hC, 32'h40);
        checkOutput("redir_new_e1", 32'(valid3), 32'd0);
        applyStimulus(32'hC, 32'h40);
        checkOutput("redir_new_e2", 32'(valid3), 32'd0);
        applyStimulus(32'hC, 32'h40);
        checkOutput("redir_new_e3", 32'(valid3), 32'd0);
        applyStimulus(32'hC, 32'h40);
        checkOutput("redir_valid",  32'(valid3), 32'd1);
        checkOutput("redir_data",   data3,       32'hA5A5_0016);

        // Load to the held word is forwarded in the same cycle.
        applyStimulus(32'h20, 32'h40);
        checkOutput("byp_pre_data",  data0,       32'h0808);
        checkOutput("byp_pre_valid", 32'(valid0), 32'd1);
        ld_we = 1'b1; ld_addr = 32'h20; ld_data = 32'hDEAD_BEEF;
        applyStimulus(32'h20, 32'h40);
        checkOutput("byp_data",  data0,       32'hDEAD_BEEF);
        checkOutput("byp_valid", 32'(valid0), 32'd1);
        ld_we = 1'b0;
        applyStimulus(32'h20, 32'h40);
        checkOutput("byp_after_data", data0, 32'hDEAD_BEEF);

        // Load to the pending word mid-wait is picked up without restarting.
        applyStimulus(32'h20, 32'h4);
        checkOutput("wrw_e1", 32'(valid3), 32'd0);
        applyStimulus(32'h20, 32'h4);
        checkOutput("wrw_e2", 32'(valid3), 32'd0);
        ld_we = 1'b1; ld_addr = 32'h4; ld_data = 32'h1234_5678;
        applyStimulus(32'h20, 32'h4);
        checkOutput("wrw_e3", 32'(valid3), 32'd0);
        checkOutput("wrw_other_data0", data0, 32'hDEAD_BEEF);
        ld_we = 1'b0;
        applyStimulus(32'h20, 32'h4);
        checkOutput("wrw_valid", 32'(valid3), 32'd1);
        checkOutput("wrw_data",  data3,       32'h1234_5678);

        // Out-of-range fetch returns NOP and sets the sticky flag.
        applyStimulus(32'h0001_0000, 32'h0001_0000);
        checkOutput("oor0_valid", 32'(valid0), 32'd1);
        checkOutput("oor0_data",  data0,       32'h13);
        checkOutput("oor0_flag",  32'(oor0),   32'd1);
        checkOutput("oor3_e1_valid", 32'(valid3), 32'd0);
        checkOutput("oor3_e1_flag",  32'(oor3),   32'd0);
        applyStimulus(32'h0, 32'h0001_0000);
        checkOutput("oor0_back_data",  data0,       32'h11);
        checkOutput("oor0_back_valid", 32'(valid0), 32'd1);
        checkOutput("oor0_sticky",     32'(oor0),   32'd1);
        checkOutput("oor3_e2_valid",   32'(valid3), 32'd0);
        applyStimulus(32'h0, 32'h0001_0000);
        checkOutput("oor3_e3_valid", 32'(valid3), 32'd0);
        applyStimulus(32'h0, 32'h0001_0000);
        checkOutput("oor3_valid", 32'(valid3), 32'd1);
        checkOutput("oor3_data",  data3,       32'h13);
        checkOutput("oor3_flag",  32'(oor3),   32'd1);

        // Asynchronous reset between edges, two edges into a wait.
        applyStimulus(32'h0, 32'h8);
        checkOutput("oor3_sticky", 32'(oor3),   32'd1);
        checkOutput("pre_rst_e1",  32'(valid3), 32'd0);
        applyStimulus(32'h0, 32'h8);
        checkOutput("pre_rst_e2",  32'(valid3), 32'd0);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_valid0", 32'(valid0), 32'd0);
        checkOutput("arst_data0",  data0,       32'd0);
        checkOutput("arst_oor0",   32'(oor0),   32'd0);
        checkOutput("arst_valid3", 32'(valid3), 32'd0);
        checkOutput("arst_data3",  data3,       32'd0);
        checkOutput("arst_oor3",   32'(oor3),   32'd0);
        applyStimulus(32'h0, 32'h8);
        checkOutput("arst_hold_valid3", 32'(valid3), 32'd0);
        rst = 1'b0;
        applyStimulus(32'h0, 32'h8);
        checkOutput("post_rst_valid0", 32'(valid0), 32'd1);
        checkOutput("post_rst_data0",  data0,       32'h11);
        checkOutput("post_rst_e1",     32'(valid3), 32'd0);
        applyStimulus(32'h0, 32'h8);
        checkOutput("post_rst_e2", 32'(valid3), 32'd0);
        applyStimulus(32'h0, 32'h8);
        checkOutput("post_rst_e3", 32'(valid3), 32'd0);
        applyStimulus(32'h0, 32'h8);
        checkOutput("post_rst_valid3", 32'(valid3), 32'd1);
        checkOutput("post_rst_data3",  data3,       32'h33);
        checkOutput("post_rst_oor3",   32'(oor3),   32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
